seq_chunk_adder: RTL



---
 rtl/seq_chunk_adder_pkg.sv | 21 ++
 rtl/seq_chunk_adder_rca_chunk.sv | 25 ++
 rtl/seq_chunk_adder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and elaboration helpers for seq_chunk_adder.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Index register needs at least one bit even when a single chunk covers the word.
  function automatic int unsigned idx_width(input int unsigned width, input int unsigned chunk);
    int unsigned n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder made of full adders.
module rca_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co = c[CHUNK];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, valid/ready on both sides.
// Optional subtract support is enabled by defining SEQ_ADD_SUB_EN.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = idx_width(WIDTH, CHUNK);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_chunk_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  state_e            state_q;
  logic              in_ready_q, out_valid_q, cout_q, ovf_q, carry_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_d, b_eff;
  logic [IDXW-1:0]   idx_q;
  logic              c_init;
  logic [CHUNK-1:0]  x_s, y_s, s_s;
  logic              co_s;

`ifdef SEQ_ADD_SUB_EN
  assign b_eff  = sub ? ~b : b;
  assign c_init = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign c_init     = cin;
`endif

  assign x_s = a_q[idx_q*CHUNK +: CHUNK];
  assign y_s = b_q[idx_q*CHUNK +: CHUNK];

  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .x  (x_s),
    .y  (y_s),
    .ci (carry_q),
    .s  (s_s),
    .co (co_s)
  );

  always_comb begin
    sum_d = sum_q;
    sum_d[idx_q*CHUNK +: CHUNK] = s_s;
  end

  // DONE spends its first cycle raising out_valid and capturing cout/ovf from the final carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b_eff;
            carry_q    <= c_init;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= co_s;
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            cout_q      <= carry_q;
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum_q[WIDTH-1] != a_q[WIDTH-1]);
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
